// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake.
// SKID=1: two-entry stage (main + skid) whose in_ready depends only on state.
// SKID=0: single-entry stage with in_ready combinationally derived from out_ready.
// Control outputs are forced to zero whenever no word is presented.
module pipe_stage_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 6,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q;
    logic              main_vld_q;
    logic [DATA_W-1:0] main_data_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic              skid_vld_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [1:0]        count_q;

    logic              accept;
    logic              pop;

    // Upstream ready and the two handshake strobes
    always_comb begin
        if (SKID != 0) begin
            in_ready = (state_q != TWO);
        end else begin
            in_ready = !main_vld_q || out_ready;
        end
        accept = in_valid && in_ready;
        pop    = main_vld_q && out_ready;
    end

    // Stage FSM: occupancy state, storage registers and held-entry count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            count_q     <= 2'd0;
        end else if (flush) begin
            // Payload registers keep their last contents; only validity is killed.
            state_q    <= EMPTY;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                        main_vld_q  <= 1'b1;
                        count_q     <= 2'd1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data_q <= in_data;
                        main_ctrl_q <= in_ctrl;
                    end else if (accept) begin
                        // Only reachable with SKID=1: in the single-entry build
                        // in_ready is low whenever main is held and not popping.
                        skid_data_q <= in_data;
                        skid_ctrl_q <= in_ctrl;
                        skid_vld_q  <= 1'b1;
                        count_q     <= 2'd2;
                        state_q     <= TWO;
                    end else if (pop) begin
                        main_vld_q <= 1'b0;
                        count_q    <= 2'd0;
                        state_q    <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_data_q <= skid_data_q;
                        main_ctrl_q <= skid_ctrl_q;
                        skid_vld_q  <= 1'b0;
                        count_q     <= 2'd1;
                        state_q     <= ONE;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    main_vld_q <= 1'b0;
                    skid_vld_q <= 1'b0;
                    count_q    <= 2'd0;
                end
            endcase
        end
    end

    // Presented word; control is gated to zero on bubbles, data is left as loaded
    always_comb begin
        out_valid = main_vld_q;
        out_data  = main_data_q;
        out_ctrl  = main_vld_q ? main_ctrl_q : '0;
        count     = count_q;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [15:0] d;
        logic [5:0]  c;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [5:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  out_ctrl;
    logic [1:0]  count;

    logic        flush0;
    logic        in_valid0;
    logic        in_ready0;
    logic [15:0] in_data0;
    logic [5:0]  in_ctrl0;
    logic        out_valid0;
    logic        out_ready0;
    logic [15:0] out_data0;
    logic [5:0]  out_ctrl0;
    logic [1:0]  count0;

    int tests_run = 0;
    int fails     = 0;
    entry_t sb[$];

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(6), .SKID(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .count(count)
    );

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(6), .SKID(0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .out_ctrl(out_ctrl0),
        .count(count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of the SKID=1 DUT against the queue model, called at a negedge
    // with inputs already applied; returns at the next negedge.
    task automatic step();
        logic   exp_rdy;
        logic   exp_vld;
        entry_t e;
        #1;
        exp_rdy = (sb.size() < 2);
        exp_vld = (sb.size() != 0);
        tests_run++;
        if (out_valid !== exp_vld) begin
            fails++;
            $display("FAIL sb_out_valid: got %b expected %b", out_valid, exp_vld);
        end
        tests_run++;
        if (count !== 2'(sb.size())) begin
            fails++;
            $display("FAIL sb_count: got %0d expected %0d", count, sb.size());
        end
        tests_run++;
        if (in_ready !== exp_rdy) begin
            fails++;
            $display("FAIL sb_in_ready: got %b expected %b", in_ready, exp_rdy);
        end
        if (exp_vld) begin
            e = sb[0];
            tests_run++;
            if (out_data !== e.d || out_ctrl !== e.c) begin
                fails++;
                $display("FAIL sb_word: got %h/%h expected %h/%h", out_data, out_ctrl, e.d, e.c);
            end
            if (out_ready) void'(sb.pop_front());
        end else begin
            tests_run++;
            if (out_ctrl !== 6'd0) begin
                fails++;
                $display("FAIL sb_bubble_ctrl: got %h expected 00", out_ctrl);
            end
        end
        if (flush) begin
            sb.delete();
        end else if (in_valid && exp_rdy) begin
            e.d = in_data;
            e.c = in_ctrl;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 16'h5555; in_ctrl = 6'h3F; out_ready = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; in_ctrl0 = '0; out_ready0 = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== 6'd0 || out_data !== 16'd0 || count !== 2'd0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_values: got v=%b c=%h d=%h n=%0d r=%b expected 0/00/0000/0/1",
                     out_valid, out_ctrl, out_data, count, in_ready);
        end
        tests_run++;
        if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
            fails++;
            $display("FAIL reset_skid0: got r=%b v=%b expected 1/0", in_ready0, out_valid0);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ignores_accept: got n=%0d v=%b expected 0/0", count, out_valid);
        end
        idle();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int unsigned i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            in_ctrl  = 6'(i);
            step();
        end
        idle();
        step();
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'hAAAA; in_ctrl = 6'h01;
        step();
        in_data = 16'hBBBB; in_ctrl = 6'h02;
        step();
        in_data = 16'hDDDD;
        #1;
        tests_run++;
        if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'hAAAA) begin
            fails++;
            $display("FAIL backpressure_full: got n=%0d r=%b d=%h expected 2/0/aaaa", count, in_ready, out_data);
        end
        step();
        idle();
        out_ready = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111; in_ctrl = 6'h01;
        step();
        in_data = 16'h2222;
        step();
        in_data = 16'hCCCC; in_ctrl = 6'h3F; flush = 1'b1;
        step();
        idle();
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== 6'd0 || count !== 2'd0 || out_data === 16'hCCCC) begin
            fails++;
            $display("FAIL flush_two: got v=%b c=%h n=%0d d=%h expected 0/00/0/not-cccc",
                     out_valid, out_ctrl, count, out_data);
        end
        step();
        // flush from ONE with in_ready high and a pop in the same cycle
        in_valid = 1'b1; in_data = 16'h3333; in_ctrl = 6'h05;
        step();
        out_ready = 1'b1; in_data = 16'hCCCC; flush = 1'b1;
        step();
        idle();
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || count !== 2'd0 || out_data === 16'hCCCC) begin
            fails++;
            $display("FAIL flush_one: got v=%b n=%0d d=%h expected 0/0/not-cccc", out_valid, count, out_data);
        end
        step();
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'h00B1; in_ctrl = 6'b000001;
        step();
        idle();
        step();
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== 6'b000000) begin
            fails++;
            $display("FAIL bubble: got v=%b c=%b expected 0/000000", out_valid, out_ctrl);
        end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234; in_ctrl = 6'b111111;
        step();
        idle();
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== 6'd0 || count !== 2'd0 || out_data !== 16'd0) begin
            fails++;
            $display("FAIL async_reset: got v=%b c=%h n=%0d d=%h expected 0/00/0/0000",
                     out_valid, out_ctrl, count, out_data);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1; in_data = 16'h4321; in_ctrl = 6'h02; out_ready = 1'b1;
        step();
        idle();
        step();
        step();
    endtask

    task automatic test_skid0();
        out_ready0 = 1'b0;
        in_valid0 = 1'b1; in_data0 = 16'h1111; in_ctrl0 = 6'h01;
        @(negedge clk);
        in_data0 = 16'h2222; in_ctrl0 = 6'h02;
        #1;
        tests_run++;
        if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || out_data0 !== 16'h1111) begin
            fails++;
            $display("FAIL skid0_block: got v=%b r=%b d=%h expected 1/0/1111", out_valid0, in_ready0, out_data0);
        end
        out_ready0 = 1'b1;
        #1;
        tests_run++;
        if (in_ready0 !== 1'b1) begin
            fails++;
            $display("FAIL skid0_ready_comb: got %b expected 1", in_ready0);
        end
        @(negedge clk);
        in_valid0 = 1'b0;
        #1;
        tests_run++;
        if (out_data0 !== 16'h2222 || out_ctrl0 !== 6'h02 || count0 !== 2'd1) begin
            fails++;
            $display("FAIL skid0_replace: got d=%h c=%h n=%0d expected 2222/02/1", out_data0, out_ctrl0, count0);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid0 !== 1'b0 || out_ctrl0 !== 6'd0 || count0 !== 2'd0) begin
            fails++;
            $display("FAIL skid0_drain: got v=%b c=%h n=%0d expected 0/00/0", out_valid0, out_ctrl0, count0);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int unsigned i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            in_ctrl   = 6'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        out_ready = 1'b1;
        step();
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
        test_async_reset();
        test_skid0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 16: width of the data payload in bits (>=1).
REQ-002 Parameter CTRL_W, default 6: width of the control bundle in bits (>=1); bit 0 is the reg-write enable by convention.
REQ-003 Parameter SKID, default 1: 1 selects a 2-entry registered-ready stage; 0 selects a 1-entry stage with combinational ready.
REQ-004 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low (asserted when 0).
REQ-006 flush  input  1  synchronous kill of all held entries.
REQ-007 in_valid  input  1  upstream offers a word.
REQ-008 in_ready  output  1  stage accepts a word this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control bundle.
REQ-011 out_valid  output  1  stage presents a word.
REQ-012 out_ready  input  1  downstream consumes the presented word.
REQ-013 out_data  output  DATA_W  presented payload.
REQ-014 out_ctrl  output  CTRL_W  presented control bundle.
REQ-015 count  output  2  number of held entries (0..2).

Function
REQ-016 A transfer in ("accept") occurs when in_valid && in_ready; a transfer out ("pop") occurs when out_valid && out_ready.
REQ-017 Storage: main register (drives out_*) and, when SKID=1, one skid register; each holds data, ctrl and a valid bit.
REQ-018 States: EMPTY (count 0), ONE (main valid), TWO (main and skid valid); TWO is unreachable when SKID=0.
REQ-019 SKID=1: in_ready = 1 in EMPTY and ONE, 0 in TWO; in_ready is a function of registered state only.
REQ-020 SKID=0: in_ready = !out_valid || out_ready (combinational path from out_ready).
REQ-021 EMPTY: accept -> ONE, main <= in.
REQ-022 ONE: accept and pop -> ONE, main <= in; accept only -> TWO, skid <= in (SKID=1); pop only -> EMPTY; neither -> ONE, hold.
REQ-023 TWO: pop -> ONE, main <= skid; no pop -> TWO, hold; no accept is possible.
REQ-024 Latency: an accepted word appears on out_* on the cycle after acceptance when the stage was EMPTY or popping; throughput one word per cycle with out_ready held high.
REQ-025 Ordering is strict FIFO; no word is duplicated or dropped except by flush.
REQ-026 While out_valid && !out_ready, out_data and out_ctrl hold stable.
REQ-027 Bubble rule: out_ctrl = 0 whenever out_valid = 0, so an empty stage never asserts reg-write or any other control.
REQ-028 out_data value is don't-care when out_valid = 0, but holds the last value loaded (no forced zero).
REQ-029 flush = 1: next state EMPTY, both valid bits cleared, count 0; a word offered in the same cycle is discarded even if in_ready = 1; the pop in that cycle still completes downstream.
REQ-030 flush overrides every other transition in the same cycle.
REQ-031 count = number of valid bits set; it updates on the same edge as state.

Reset
REQ-032 rst = 0 immediately, without a clock edge, forces state EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid contents 0, count 0.
REQ-033 During reset, in_ready = 1 (SKID=1) or 1 (SKID=0, since out_valid = 0); accepts are ignored while rst = 0.
REQ-034 Reset asserted mid-transfer discards all held words; the first edge after release behaves as from EMPTY.

Verification
REQ-035 Streaming: SKID=1, out_ready = 1, in_valid = 1 with data 0x0001..0x0008 on consecutive cycles -> out_data 0x0001..0x0008 one cycle later each, count stays 1, in_ready stays 1.
REQ-036 Backpressure: load 0xAAAA, drop out_ready, offer 0xBBBB -> count 2, in_ready 0, out_data holds 0xAAAA; raise out_ready -> 0xAAAA then 0xBBBB popped, count 2 -> 1 -> 0.
REQ-037 Flush collision: in TWO with in_valid = 1 and data 0xCCCC, assert flush for one cycle -> next cycle out_valid 0, out_ctrl 0, count 0, 0xCCCC never appears on out_data.
REQ-038 Bubble: ctrl 6'b000001 accepted then popped with no new input -> out_valid 0 and out_ctrl 6'b000000 on the following cycle.
REQ-039 Async reset: in ONE holding 0x1234 with ctrl 6'b111111, pull rst low between edges -> out_valid, out_ctrl, count read 0 before the next rising edge.
REQ-040 SKID=0: out_ready = 0 with main valid -> in_ready 0 in the same cycle; out_ready = 1 -> in_ready 1 in the same cycle and a simultaneous accept replaces main.
